eject_sink: RTL and testbench
=============================

# eject_sink

Ejection-side consumer attached to a router's local output port. It accepts flits leaving the network, reassembles them into packets per virtual channel, and returns one credit per flit after a fixed delay. It also reports a completion pulse per packet and keeps saturating flit/packet counters plus sticky protocol-error flags for the bench. One instance sits downstream of each `router` in `main`, on the local ejection port.

## Interface
- `NUM_VC`, default 4: number of virtual channels (1..8).
- `VC_BITS`, default 2: width of VC index, equal to clog2(NUM_VC), minimum 1.
- `DST_BITS`, default 6: router-id width.
- `FLIT_W`, default 32: payload width.
- `CREDIT_DELAY`, default 2: flit-to-credit latency in cycles (1..15).
- `CNT_W`, default 16: statistics counter width.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `my_id` in DST_BITS: id of the owning router; static after reset.
- `in_valid` in 1: flit present this cycle.
- `in_head` in 1: flit is a head.
- `in_tail` in 1: flit is a tail. Head and tail both set means a single-flit packet.
- `in_vc` in VC_BITS: VC of the flit.
- `in_dst` in DST_BITS: destination field of the flit.
- `in_data` in FLIT_W: payload. Ignored except for packet parity.
- `cr_valid` out 1: credit return strobe toward the router.
- `cr_vc` out VC_BITS: VC being credited.
- `pkt_done` out 1: one-cycle pulse, a packet has completed cleanly.
- `pkt_vc` out VC_BITS: VC of the completed packet.
- `pkt_len` out 8: flit count of the completed packet, saturating at 255.
- `pkt_parity` out 1: XOR-reduce of all payload bits of the packet.
- `flit_count` out CNT_W: total accepted flits, saturating.
- `pkt_count` out CNT_W: total clean packets, saturating.
- `err` out 3: sticky error flags. [0] body or tail flit arrived on an idle VC. [1] head flit arrived on a busy VC. [2] `in_dst` != `my_id`.

## Operation
- There is no backpressure. Every cycle with `in_valid`=1 accepts exactly one flit.
- Each VC has a 2-state FSM (IDLE, BUSY), an 8-bit length counter, and a parity bit.
- IDLE with head&tail: packet completes immediately with length 1. FSM stays IDLE.
- IDLE with head only: move to BUSY, set length=1, parity=^in_data.
- IDLE with body or tail: set err[0]. The flit is dropped from reassembly but is still counted and credited.
- BUSY with body: length+1 (saturating at 255), XOR parity.
- BUSY with tail: packet completes with length+1. Return to IDLE.
- BUSY with head: set err[1]. The old packet is abandoned, not counted and not pulsed. A new packet starts from this head, including when the head is also a tail.
- Destination mismatch: set err[2]. The flit is processed normally otherwise.
- `err` bits are OR-accumulated and cleared only by `rst`.
- Every accepted flit pushes its VC into a CREDIT_DELAY-deep shift pipeline. The pipeline output drives `cr_valid`/`cr_vc`. At most one credit per cycle, and credits leave in arrival order.
- `flit_count` increments per accepted flit. `pkt_count` increments per clean completion. Both hold at all-ones.
- When the pipeline carries no credit, `cr_vc` = 0. When `pkt_done`=0, `pkt_vc`, `pkt_len` and `pkt_parity` = 0.

## Timing
- All outputs are registered.
- Flit valid in cycle n produces `cr_valid`=1 with that VC in cycle n+CREDIT_DELAY.
- A completing flit in cycle n produces `pkt_done` in cycle n+1. `pkt_count` shows the increment in cycle n+1.
- `flit_count` and `err` update in cycle n+1.
- Back-to-back tails on different VCs in consecutive cycles give `pkt_done` in consecutive cycles.
- Reset:
  - All outputs read 0 from the cycle after `rst` is sampled high.
  - All FSMs return to IDLE, and lengths and parity clear.
  - The credit pipeline is flushed. Credits in flight are dropped, not replayed.
  - A flit presented while `rst`=1 is ignored.
- Reset mid-packet discards partial packets. The first flit after reset on that VC must be a head, otherwise err[0] is set.

## Test plan
- With reset, then a single-flit packet (head&tail, vc=2, dst=my_id=5, data=0x1) in cycle 10: `pkt_done`, vc=2, len=1, parity=1 in cycle 11. `cr_valid`/vc=2 in cycle 12 (CREDIT_DELAY=2). `pkt_count`=1, `err`=0.
- A 4-flit packet on vc 1 interleaved flit-by-flit with a 3-flit packet on vc 3: two pulses with len 4 and 3 on the correct VCs, 7 credits in arrival order, `flit_count`=7.
- Body flit on idle vc 0 sets err=3'b001 with no pulse and one credit. A head on busy vc 1 sets err[1] and only the second packet is reported. A flit with dst=6 while my_id=5 sets err[2].
- Stream 300 body flits after a head, then a tail: `pkt_len`=255. Preload so that `flit_count` wraps past all-ones: it holds at 0xFFFF.
- Assert `rst` for one cycle while 2 credits are in flight and vc 0 is BUSY: no `cr_valid` afterward, and all counters and `err` are 0. A subsequent tail on vc 0 sets err[0].
- With CREDIT_DELAY=1, 8 consecutive flits give `cr_valid` continuously from cycle n+1 through n+8.

Source files
------------

// File: rtl/eject_sink.sv
// eject_sink: per-VC packet reassembly, delayed credit return, saturating stats and sticky error flags
module eject_sink #(
   parameter int NUM_VC       = 4,
   parameter int VC_BITS      = 2,
   parameter int DST_BITS     = 6,
   parameter int FLIT_W       = 32,
   parameter int CREDIT_DELAY = 2,
   parameter int CNT_W        = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [DST_BITS-1:0] my_id,
   input  logic                in_valid,
   input  logic                in_head,
   input  logic                in_tail,
   input  logic [VC_BITS-1:0]  in_vc,
   input  logic [DST_BITS-1:0] in_dst,
   input  logic [FLIT_W-1:0]   in_data,
   output logic                cr_valid,
   output logic [VC_BITS-1:0]  cr_vc,
   output logic                pkt_done,
   output logic [VC_BITS-1:0]  pkt_vc,
   output logic [7:0]          pkt_len,
   output logic                pkt_parity,
   output logic [CNT_W-1:0]    flit_count,
   output logic [CNT_W-1:0]    pkt_count,
   output logic [2:0]          err
);
   logic [NUM_VC-1:0]                     busy_q, busy_d, par_q, par_d;
   logic [NUM_VC-1:0][7:0]                len_q, len_d;
   logic [CREDIT_DELAY-1:0]               cv_q, cv_d;
   logic [CREDIT_DELAY-1:0][VC_BITS-1:0]  cc_q, cc_d;
   logic                                  pkt_done_q, pkt_done_d, pkt_par_q, pkt_par_d;
   logic [VC_BITS-1:0]                    pkt_vc_q, pkt_vc_d;
   logic [7:0]                            pkt_len_q, pkt_len_d, len_inc, done_len;
   logic [CNT_W-1:0]                      flit_count_q, flit_count_d, pkt_count_q, pkt_count_d;
   logic [2:0]                            err_q, err_d;
   logic                                  flit_par, done, done_par;

   always_comb begin
      flit_par = ^in_data;
      len_inc = (&len_q[in_vc]) ? len_q[in_vc] : len_q[in_vc] + 8'd1;
      busy_d = busy_q;
      len_d = len_q;
      par_d = par_q;
      err_d = err_q;
      done = 1'b0;
      done_len = 8'd0;
      done_par = 1'b0;
      flit_count_d = (in_valid && !(&flit_count_q)) ? flit_count_q + CNT_W'(1) : flit_count_q;
      if (in_valid) begin
         err_d[2] = err_q[2] | (in_dst != my_id);
         // a head always starts a fresh packet, abandoning any packet in progress
         if (in_head) begin
            err_d[1] = err_q[1] | busy_q[in_vc];
            busy_d[in_vc] = !in_tail;
            len_d[in_vc] = in_tail ? 8'd0 : 8'd1;
            par_d[in_vc] = !in_tail & flit_par;
            done = in_tail;
            done_len = 8'd1;
            done_par = flit_par;
         end else if (!busy_q[in_vc]) begin
            err_d[0] = 1'b1;
         end else begin
            busy_d[in_vc] = !in_tail;
            len_d[in_vc] = in_tail ? 8'd0 : len_inc;
            par_d[in_vc] = !in_tail & (par_q[in_vc] ^ flit_par);
            done = in_tail;
            done_len = len_inc;
            done_par = par_q[in_vc] ^ flit_par;
         end
      end
      pkt_done_d = done;
      pkt_vc_d = done ? in_vc : '0;
      pkt_len_d = done ? done_len : 8'd0;
      pkt_par_d = done & done_par;
      pkt_count_d = (done && !(&pkt_count_q)) ? pkt_count_q + CNT_W'(1) : pkt_count_q;
      // credit VC is zeroed when no flit so the pipe output reads 0 when idle
      cv_d[0] = in_valid;
      cc_d[0] = in_valid ? in_vc : '0;
      for (int i = 1; i < CREDIT_DELAY; i++) begin
         cv_d[i] = cv_q[i-1];
         cc_d[i] = cc_q[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q <= '0;
         par_q <= '0;
         len_q <= '0;
         cv_q <= '0;
         cc_q <= '0;
         pkt_done_q <= 1'b0;
         pkt_vc_q <= '0;
         pkt_len_q <= 8'd0;
         pkt_par_q <= 1'b0;
         flit_count_q <= '0;
         pkt_count_q <= '0;
         err_q <= 3'd0;
      end else begin
         busy_q <= busy_d;
         par_q <= par_d;
         len_q <= len_d;
         cv_q <= cv_d;
         cc_q <= cc_d;
         pkt_done_q <= pkt_done_d;
         pkt_vc_q <= pkt_vc_d;
         pkt_len_q <= pkt_len_d;
         pkt_par_q <= pkt_par_d;
         flit_count_q <= flit_count_d;
         pkt_count_q <= pkt_count_d;
         err_q <= err_d;
      end
   end

   assign cr_valid = cv_q[CREDIT_DELAY-1];
   assign cr_vc = cc_q[CREDIT_DELAY-1];
   assign pkt_done = pkt_done_q;
   assign pkt_vc = pkt_vc_q;
   assign pkt_len = pkt_len_q;
   assign pkt_parity = pkt_par_q;
   assign flit_count = flit_count_q;
   assign pkt_count = pkt_count_q;
   assign err = err_q;
endmodule

// File: tb/tb_eject_sink.sv
// tb_eject_sink: drives two eject_sink instances (credit delay 2 / 8-bit counters and credit delay 1 / 16-bit counters) against a packet-level model
module tb_eject_sink;
   localparam logic [5:0] MY_ID = 6'd5;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic in_valid = 1'b0, in_head = 1'b0, in_tail = 1'b0;
   logic [1:0] in_vc = 2'd0;
   logic [5:0] in_dst = MY_ID;
   logic [31:0] in_data = 32'd0;

   logic a_cr_valid, a_pkt_done, a_pkt_parity, b_cr_valid, b_pkt_done, b_pkt_parity;
   logic [1:0] a_cr_vc, a_pkt_vc, b_cr_vc, b_pkt_vc;
   logic [7:0] a_pkt_len, b_pkt_len, a_flit_count, a_pkt_count;
   logic [15:0] b_flit_count, b_pkt_count;
   logic [2:0] a_err, b_err;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   eject_sink #(.CREDIT_DELAY(2), .CNT_W(8)) u_a (
      .clk(clk), .rst(rst), .my_id(MY_ID), .in_valid(in_valid), .in_head(in_head), .in_tail(in_tail),
      .in_vc(in_vc), .in_dst(in_dst), .in_data(in_data), .cr_valid(a_cr_valid), .cr_vc(a_cr_vc),
      .pkt_done(a_pkt_done), .pkt_vc(a_pkt_vc), .pkt_len(a_pkt_len), .pkt_parity(a_pkt_parity),
      .flit_count(a_flit_count), .pkt_count(a_pkt_count), .err(a_err));

   eject_sink #(.CREDIT_DELAY(1), .CNT_W(16)) u_b (
      .clk(clk), .rst(rst), .my_id(MY_ID), .in_valid(in_valid), .in_head(in_head), .in_tail(in_tail),
      .in_vc(in_vc), .in_dst(in_dst), .in_data(in_data), .cr_valid(b_cr_valid), .cr_vc(b_cr_vc),
      .pkt_done(b_pkt_done), .pkt_vc(b_pkt_vc), .pkt_len(b_pkt_len), .pkt_parity(b_pkt_parity),
      .flit_count(b_flit_count), .pkt_count(b_pkt_count), .err(b_err));

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d at %0t", nm, act, exp, $time);
      end
   endtask

   // packet-level model: open packets per VC, credits as due-edge records, plain integer counts
   int edge_n = 0;
   bit m_open [4];
   int m_len [4];
   bit m_par [4];
   int m_flits, m_pkts;
   bit [2:0] m_err;
   int cq_a[$], cq_b[$];
   bit e_done, e_par, e_cra, e_crb;
   int e_vc, e_len, e_cva, e_cvb;

   always @(posedge clk) begin
      edge_n++;
      e_done = 0; e_vc = 0; e_len = 0; e_par = 0;
      e_cra = 0; e_cva = 0; e_crb = 0; e_cvb = 0;
      if (rst) begin
         for (int v = 0; v < 4; v++) begin m_open[v] = 0; m_len[v] = 0; m_par[v] = 0; end
         m_flits = 0; m_pkts = 0; m_err = 0;
         cq_a.delete(); cq_b.delete();
      end else begin
         if (in_valid) begin
            m_flits++;
            if (in_dst != MY_ID) m_err[2] = 1;
            cq_a.push_back((edge_n + 1) * 16 + int'(in_vc));
            cq_b.push_back(edge_n * 16 + int'(in_vc));
            if (in_head) begin
               if (m_open[in_vc]) m_err[1] = 1;
               m_open[in_vc] = 1; m_len[in_vc] = 0; m_par[in_vc] = 0;
            end
            if (!m_open[in_vc]) m_err[0] = 1;
            else begin
               m_len[in_vc]++;
               m_par[in_vc] ^= ^in_data;
               if (in_tail) begin
                  e_done = 1; e_vc = in_vc; e_len = m_len[in_vc] > 255 ? 255 : m_len[in_vc]; e_par = m_par[in_vc];
                  m_pkts++; m_open[in_vc] = 0;
               end
            end
         end
         if (cq_a.size() > 0 && cq_a[0] / 16 == edge_n) begin e_cra = 1; e_cva = cq_a[0] % 16; void'(cq_a.pop_front()); end
         if (cq_b.size() > 0 && cq_b[0] / 16 == edge_n) begin e_crb = 1; e_cvb = cq_b[0] % 16; void'(cq_b.pop_front()); end
      end
   end

   always @(negedge clk) begin
      if (edge_n >= 1) begin
         chk("a_cr_valid", a_cr_valid, e_cra); chk("a_cr_vc", a_cr_vc, e_cva);
         chk("b_cr_valid", b_cr_valid, e_crb); chk("b_cr_vc", b_cr_vc, e_cvb);
         chk("a_pkt_done", a_pkt_done, e_done); chk("a_pkt_vc", a_pkt_vc, e_vc);
         chk("a_pkt_len", a_pkt_len, e_len); chk("a_pkt_parity", a_pkt_parity, e_par);
         chk("b_pkt_done", b_pkt_done, e_done); chk("b_pkt_len", b_pkt_len, e_len);
         chk("a_flit_count", a_flit_count, m_flits > 255 ? 255 : m_flits);
         chk("b_flit_count", b_flit_count, m_flits > 65535 ? 65535 : m_flits);
         chk("a_pkt_count", a_pkt_count, m_pkts > 255 ? 255 : m_pkts);
         chk("b_pkt_count", b_pkt_count, m_pkts);
         chk("a_err", a_err, m_err); chk("b_err", b_err, m_err);
      end
   end

   task automatic send(input bit h, input bit t, input int vc, input logic [5:0] dst, input logic [31:0] d);
      @(negedge clk);
      in_valid = 1; in_head = h; in_tail = t; in_vc = 2'(vc); in_dst = dst; in_data = d;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         in_valid = 0; in_head = 0; in_tail = 0; in_vc = 0; in_dst = MY_ID; in_data = 0;
      end
   endtask

   task automatic pulse_rst;
      @(negedge clk); rst = 1; in_valid = 0;
      @(negedge clk); rst = 0;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      rst = 0;
      idle(5);
      chk("lit_reset_flits", a_flit_count, 0);
      // single-flit packet
      send(1, 1, 2, MY_ID, 32'h1);
      idle(1);
      chk("lit_single_done", a_pkt_done, 1); chk("lit_single_vc", a_pkt_vc, 2);
      chk("lit_single_len", a_pkt_len, 1); chk("lit_single_par", a_pkt_parity, 1);
      chk("lit_single_cnt", a_pkt_count, 1); chk("lit_b_credit_d1", b_cr_valid, 1);
      idle(1);
      chk("lit_a_credit_d2", a_cr_valid, 1); chk("lit_a_credit_vc", a_cr_vc, 2);
      idle(2);
      // interleaved 4-flit vc1 and 3-flit vc3
      send(1, 0, 1, MY_ID, 32'h3); send(1, 0, 3, MY_ID, 32'h1);
      send(0, 0, 1, MY_ID, 32'h1); send(0, 0, 3, MY_ID, 32'h0);
      send(0, 0, 1, MY_ID, 32'h7); send(0, 1, 3, MY_ID, 32'h2);
      send(0, 1, 1, MY_ID, 32'h0);
      chk("lit_vc3_vc", a_pkt_vc, 3); chk("lit_vc3_len", a_pkt_len, 3);
      idle(1);
      chk("lit_vc1_vc", a_pkt_vc, 1); chk("lit_vc1_len", a_pkt_len, 4); chk("lit_flits8", a_flit_count, 8);
      idle(3);
      // body on idle vc0
      send(0, 0, 0, MY_ID, 32'h5);
      idle(1);
      chk("lit_err0", a_err, 1); chk("lit_err0_nodone", a_pkt_done, 0);
      idle(2);
      // head on busy vc1 abandons the old packet
      send(1, 0, 1, MY_ID, 32'h0); send(0, 0, 1, MY_ID, 32'h0);
      send(1, 0, 1, MY_ID, 32'h1); send(0, 1, 1, MY_ID, 32'h0);
      idle(1);
      chk("lit_err1", a_err, 3); chk("lit_restart_len", a_pkt_len, 2); chk("lit_restart_par", a_pkt_parity, 1);
      chk("lit_pkts4", a_pkt_count, 4);
      // destination mismatch mid-packet
      send(1, 0, 2, MY_ID, 32'h0); send(0, 0, 2, 6'd6, 32'h0); send(0, 1, 2, MY_ID, 32'h0);
      idle(1);
      chk("lit_err2", a_err, 7); chk("lit_dst_len", a_pkt_len, 3);
      pulse_rst();
      chk("lit_rst_err", a_err, 0);
      // long packet saturates length and the 8-bit flit counter
      send(1, 0, 0, MY_ID, 32'h0);
      for (int i = 0; i < 300; i++) send(0, 0, 0, MY_ID, 32'(i));
      send(0, 1, 0, MY_ID, 32'h1);
      idle(1);
      chk("lit_len_sat", a_pkt_len, 255); chk("lit_a_flit_sat", a_flit_count, 255);
      chk("lit_b_flits302", b_flit_count, 302);
      idle(3);
      // reset with credits in flight and vc0 busy; the flit shown during reset is ignored
      send(1, 0, 0, MY_ID, 32'h0); send(0, 0, 0, MY_ID, 32'h0);
      @(negedge clk); rst = 1; in_head = 0; in_tail = 1;
      @(negedge clk); rst = 0; in_valid = 0; in_tail = 0;
      chk("lit_rst_cr", a_cr_valid, 0); chk("lit_rst_flits", a_flit_count, 0);
      idle(3);
      send(0, 1, 0, MY_ID, 32'h0);
      idle(1);
      chk("lit_post_rst_err0", a_err, 1);
      idle(3);
      // 8 consecutive flits: unit-delay credits back to back
      for (int i = 0; i < 8; i++) begin
         send(1, 1, i % 4, MY_ID, 32'(i));
         if (i > 0) chk("lit_b_cr_run", b_cr_valid, 1);
      end
      idle(1);
      chk("lit_b_cr_last", b_cr_valid, 1); chk("lit_b_cr_last_vc", b_cr_vc, 3);
      idle(1);
      chk("lit_b_cr_end", b_cr_valid, 0);
      idle(4);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
